// File: rtl/tt_lut_eval_seq.sv
// Runtime-loadable N-input truth-table evaluator with a registered valid/ready output.
// Optional transfer histogram enabled by defining TT_LUT_HIST_EN.
module tt_lut_eval_seq #(
  parameter int NUM_IN = 3,
  parameter logic [(2**NUM_IN)-1:0] RESET_TT = 8'hED
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN-1:0]        in_vec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_bit,
  input  logic                     cfg_start,
  input  logic                     cfg_valid,
  input  logic                     cfg_bit,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic [(2**NUM_IN)-1:0]   tt_active,
  output logic [15:0]              hist_ones
);

  localparam int TT_W = 2**NUM_IN;
  localparam int CW   = $clog2(TT_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(TT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [TT_W-1:0] shadow;
  logic [TT_W-1:0] shadow_nx;
  logic [TT_W-1:0] tt_nx;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nx;
  logic            accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      count     <= '0;
      tt_active <= RESET_TT;
    end else begin
      state     <= state_nx;
      shadow    <= shadow_nx;
      count     <= count_nx;
      tt_active <= tt_nx;
    end
  end

  // A new start always restarts the load, even one about to commit.
  always_comb begin
    state_nx  = state;
    shadow_nx = shadow;
    count_nx  = count;
    tt_nx     = tt_active;
    cfg_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nx  = LOAD;
          count_nx  = '0;
          shadow_nx = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          count_nx  = '0;
          shadow_nx = '0;
        end else if (cfg_valid) begin
          shadow_nx = (shadow << 1) | TT_W'(cfg_bit);
          if (count == LAST) begin
            state_nx = COMMIT;
          end else begin
            count_nx = count + CW'(1);
          end
        end
      end
      COMMIT: begin
        if (cfg_start) begin
          state_nx  = LOAD;
          count_nx  = '0;
          shadow_nx = '0;
        end else begin
          tt_nx    = shadow;
          cfg_done = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cfg_busy = (state != IDLE);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_bit   <= tt_active[in_vec];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef TT_LUT_HIST_EN
  logic [15:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (cfg_done) begin
      hist <= '0;
    end else if (out_valid && out_ready && out_bit && hist != 16'hFFFF) begin
      hist <= hist + 16'd1;
    end
  end

  assign hist_ones = hist;
`else
  assign hist_ones = 16'h0000;
`endif

endmodule

// File: tb/tb_tt_lut_eval_seq.sv
// Scoreboard bench for tt_lut_eval_seq: random traffic, serial loads, resets.
// Expected results come from a transaction-level table model.
module tb_tt_lut_eval_seq;

  localparam logic [7:0] RST_TT = 8'hED;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_busy;
  logic       cfg_done;
  logic [7:0] tt_active;
  logic [15:0] hist_ones;

  tt_lut_eval_seq #(.NUM_IN(3), .RESET_TT(8'hED)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .tt_active(tt_active), .hist_ones(hist_ones)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit   expq[$];
  logic [7:0] mtt;
  bit   mbits[$];
  bit   loading;
  bit   pend;

  // Model process: predicts accepted results and the table/config behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      mtt = RST_TT;
      mbits.delete();
      loading = 0;
      pend = 0;
      expq.delete();
    end else begin
      chk("tt_active", tt_active, mtt);
      chk("in_ready", in_ready, !out_valid || out_ready);
      chk("cfg_busy", cfg_busy, loading || pend);
      chk("cfg_done", cfg_done, pend && !cfg_start);
      if (in_valid && in_ready) expq.push_back(mtt[in_vec]);
      if (cfg_start) begin
        mbits.delete();
        loading = 1;
        pend = 0;
      end else if (pend) begin
        for (int i = 0; i < 8; i++) mtt[7-i] = mbits[i];
        pend = 0;
      end else if (loading && cfg_valid) begin
        mbits.push_back(cfg_bit);
        if (mbits.size() == 8) begin
          loading = 0;
          pend = 1;
        end
      end
    end
  end

  // Monitor: pops expectations on every output transfer.
  bit   hold;
  bit   hbit;
  int   mhist;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 0;
      mhist = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_bit", out_bit, hbit);
      end
      chk("hist_ones", hist_ones, mhist);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          bit e;
          e = expq.pop_front();
          chk("out_bit", out_bit, e);
`ifdef TT_LUT_HIST_EN
          if (e && mhist < 16'hFFFF) mhist++;
`endif
        end
      end
`ifdef TT_LUT_HIST_EN
      if (cfg_done) mhist = 0;
`endif
      hold = out_valid && !out_ready;
      hbit = out_bit;
    end
  end

  int vpct = 70;
  int rpct = 70;

  task automatic cyc(input bit s, input bit v, input bit b);
    cfg_start = s;
    cfg_valid = v;
    cfg_bit   = b;
    in_valid  = ($urandom_range(99) < vpct);
    in_vec    = 3'($urandom);
    out_ready = ($urandom_range(99) < rpct);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    cyc(1, 0, 0);
    for (int i = 7; i >= 0; i--) cyc(0, 1, v[i]);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    in_valid = 0;
    in_vec = 0;
    out_ready = 1;
    cfg_start = 0;
    cfg_valid = 0;
    cfg_bit = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tt", tt_active, 8'hED);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_hist", hist_ones, 0);
    do_reset();

    // Reset table sweep at full throughput
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      out_ready = 1;
      in_vec = 3'(i);
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;

    load(8'h96);
    chk("load_96", tt_active, 8'h96);
    out_ready = 1;
    in_valid = 1;
    in_vec = 3'd3;
    @(posedge clk); #1;
    in_vec = 3'd7;
    @(posedge clk); #1;
    in_vec = 3'd1;
    @(posedge clk); #1;

    // Downstream stall with pending input
    in_vec = 3'd5;
    out_ready = 0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
      in_vec = 3'($urandom);
    end
    out_ready = 1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;

    // Streaming through a commit
    vpct = 100;
    rpct = 100;
    load(8'($urandom));
    load(8'h3C);
    vpct = 70;
    rpct = 70;

    // Restart mid-load then full load
    cyc(1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1'b1);
    load(8'h01);
    chk("restart_01", tt_active, 8'h01);

    // Async reset mid-load
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1'b0);
    #3;
    rst_n = 0;
    #1;
    chk("async_rst_tt", tt_active, 8'hED);
    @(posedge clk);
    #1;
    do_reset();

    // Random traffic with occasional loads and restarts
    for (int n = 0; n < 40; n++) begin
      vpct = $urandom_range(30, 100);
      rpct = $urandom_range(30, 100);
      case ($urandom_range(3))
        0: load(8'($urandom));
        1: begin
          cyc(1, 0, 0);
          for (int i = 0; i < 8; i++)
            cyc(0, $urandom_range(1), 1'($urandom));
        end
        default: repeat (6) cyc(0, 1, 1'($urandom));
      endcase
    end

    // Drain
    cfg_start = 0;
    cfg_valid = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
